// File: rtl/mips_isa_pkg.sv
// MIPS ISA constants shared by the instruction encoder and decoder:
// opcodes, function codes, format encoding and instruction field positions.
package mips_isa_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADDU  = 6'h21;

    typedef enum logic [1:0] {
        FMT_R   = 2'd0,
        FMT_I   = 2'd1,
        FMT_J   = 2'd2,
        FMT_BAD = 2'd3
    } fmt_e;

    localparam int OP_LSB     = 26;
    localparam int RS_LSB     = 21;
    localparam int RT_LSB     = 16;
    localparam int RD_LSB     = 11;
    localparam int SHAMT_LSB  = 6;
    localparam int FUNCT_LSB  = 0;
    localparam int IMM_LSB    = 0;
    localparam int TARGET_LSB = 0;

    // The I format owns every opcode that is not R-type or a jump.
    function automatic logic fmt_legal(input fmt_e fmt, input logic [5:0] op);
        logic is_jump;
        is_jump = (op == OP_J) || (op == OP_JAL);
        case (fmt)
            FMT_R:   fmt_legal = (op == OP_RTYPE);
            FMT_I:   fmt_legal = (op != OP_RTYPE) && !is_jump;
            FMT_J:   fmt_legal = is_jump;
            default: fmt_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO; write and read in the same clock domain.
// Latency: a push is visible at the head one edge later; push/pop may coincide.
// Backpressure: full_o blocks pushes; pushes when full and pops when empty are ignored.
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push_i,
    input  logic [WIDTH-1:0]             push_dat_i,
    input  logic                         pop_i,
    output logic [WIDTH-1:0]             pop_dat_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage carries no reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
        end
    end

    assign pop_dat_o = mem_q[rd_ptr_q];
    assign count_o   = count_q;

endmodule

// File: rtl/mips_instr_encoder.sv
// Packs decoded R/I/J fields into 32-bit MIPS words tagged with sequential imem addresses.
// Latency: one edge from accept to out_*; no bypass. Illegal bundles are consumed, not queued.
// Backpressure: in_ready = !full only; out_valid/out_ready pops the FIFO head.
module mips_instr_encoder
    import mips_isa_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [1:0]                   fmt,
    input  logic [5:0]                   op,
    input  logic [4:0]                   rs,
    input  logic [4:0]                   rt,
    input  logic [4:0]                   rd,
    input  logic [4:0]                   shamt,
    input  logic [5:0]                   funct,
    input  logic [15:0]                  imm,
    input  logic [25:0]                  target,
    input  logic                         err_clr,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [31:0]                  out_instr,
    output logic [ADDR_W-1:0]            out_addr,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         err
);
    localparam int WIDTH = 32 + ADDR_W;

    logic [31:0]       instr_w;
    logic              legal;
    logic              accept;
    logic              push;
    logic              full, empty;
    logic [WIDTH-1:0]  head;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              err_q, err_d;

    always_comb begin
        instr_w = '0;
        legal   = fmt_legal(fmt_e'(fmt), op);
        case (fmt_e'(fmt))
            FMT_R: begin
                instr_w[RS_LSB    +: 5] = rs;
                instr_w[RT_LSB    +: 5] = rt;
                instr_w[RD_LSB    +: 5] = rd;
                instr_w[SHAMT_LSB +: 5] = shamt;
                instr_w[FUNCT_LSB +: 6] = funct;
            end
            FMT_I: begin
                instr_w[OP_LSB  +: 6]  = op;
                instr_w[RS_LSB  +: 5]  = rs;
                instr_w[RT_LSB  +: 5]  = rt;
                instr_w[IMM_LSB +: 16] = imm;
            end
            FMT_J: begin
                instr_w[OP_LSB     +: 6]  = op;
                instr_w[TARGET_LSB +: 26] = target;
            end
            default: instr_w = '0;
        endcase
    end

    assign in_ready = !full;
    assign accept   = in_valid && in_ready;
    assign push     = accept && legal;

    // A fresh illegal accept outranks a same-cycle clear so no error is lost.
    always_comb begin
        addr_d = push ? addr_q + ADDR_W'(1) : addr_q;
        err_d  = err_q;
        if (accept && !legal) err_d = 1'b1;
        else if (err_clr)     err_d = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q <= ADDR_W'(BASE_ADDR);
            err_q  <= 1'b0;
        end else begin
            addr_q <= addr_d;
            err_q  <= err_d;
        end
    end

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push_i     (push),
        .push_dat_i ({instr_w, addr_q}),
        .pop_i      (out_ready),
        .pop_dat_o  (head),
        .full_o     (full),
        .empty_o    (empty),
        .count_o    (count)
    );

    assign out_valid = !empty;
    assign out_instr = empty ? '0 : head[WIDTH-1:ADDR_W];
    assign out_addr  = empty ? '0 : head[ADDR_W-1:0];
    assign err       = err_q;

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Directed bench for mips_instr_encoder: packing table plus backpressure, error, reset and address-wrap sequences.
module tb_mips_instr_encoder;
    import mips_isa_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0, in_valid2 = 1'b0;
    logic        in_ready, in_ready2;
    logic [1:0]  fmt = '0;
    logic [5:0]  op = '0;
    logic [4:0]  rs = '0, rt = '0, rd = '0, shamt = '0;
    logic [5:0]  funct = '0;
    logic [15:0] imm = '0;
    logic [25:0] target = '0;
    logic        err_clr = 1'b0;
    logic        out_valid, out_valid2;
    logic        out_ready = 1'b0, out_ready2 = 1'b0;
    logic [31:0] out_instr, out_instr2;
    logic [7:0]  out_addr;
    logic [1:0]  out_addr2;
    logic [2:0]  count, count2;
    logic        err, err2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mips_instr_encoder #(.DEPTH(4), .ADDR_W(8), .BASE_ADDR(0)) u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .fmt(fmt), .op(op), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
        .imm(imm), .target(target), .err_clr(err_clr), .out_valid(out_valid),
        .out_ready(out_ready), .out_instr(out_instr), .out_addr(out_addr),
        .count(count), .err(err)
    );

    mips_instr_encoder #(.DEPTH(4), .ADDR_W(2), .BASE_ADDR(0)) u_dut2 (
        .clk(clk), .reset(reset), .in_valid(in_valid2), .in_ready(in_ready2),
        .fmt(fmt), .op(op), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
        .imm(imm), .target(target), .err_clr(err_clr), .out_valid(out_valid2),
        .out_ready(out_ready2), .out_instr(out_instr2), .out_addr(out_addr2),
        .count(count2), .err(err2)
    );

    typedef struct {
        string       name;
        logic [1:0]  fmt;
        logic [5:0]  op;
        logic [4:0]  rs, rt, rd, shamt;
        logic [5:0]  funct;
        logic [15:0] imm;
        logic [25:0] target;
        logic        legal;
        logic [31:0] instr;
    } vec_t;

    vec_t vecs [12];

    function automatic vec_t mk(input string n, input logic [1:0] f, input logic [5:0] o,
                                input logic [4:0] s, input logic [4:0] t, input logic [4:0] d,
                                input logic [4:0] sh, input logic [5:0] fn, input logic [15:0] im,
                                input logic [25:0] tg, input logic lg, input logic [31:0] ins);
        vec_t v;
        v.name = n; v.fmt = f; v.op = o; v.rs = s; v.rt = t; v.rd = d; v.shamt = sh;
        v.funct = fn; v.imm = im; v.target = tg; v.legal = lg; v.instr = ins;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t v);
        fmt = v.fmt; op = v.op; rs = v.rs; rt = v.rt; rd = v.rd; shamt = v.shamt;
        funct = v.funct; imm = v.imm; target = v.target;
    endtask

    task automatic drive_addi(input int k);
        fmt = 2'd1; op = 6'h08; rs = 5'd0; rt = 5'd1; imm = 16'(k);
    endtask

    initial begin
        int exp_addr;
        vecs[0]  = mk("r_addu",   2'd0, 6'h00, 5'd1,  5'd2,  5'd3, 5'd0, 6'h21, 16'h0,    26'h0,       1'b1, 32'h00221821);
        vecs[1]  = mk("i_addi",   2'd1, 6'h08, 5'd1,  5'd2,  5'd0, 5'd0, 6'h00, 16'hFFFF, 26'h0,       1'b1, 32'h2022FFFF);
        vecs[2]  = mk("j_jal",    2'd2, 6'h03, 5'd0,  5'd0,  5'd0, 5'd0, 6'h00, 16'h0,    26'h0100000, 1'b1, 32'h0C100000);
        vecs[3]  = mk("r_badop",  2'd0, 6'h08, 5'd1,  5'd2,  5'd3, 5'd0, 6'h21, 16'h0,    26'h0,       1'b0, 32'h0);
        vecs[4]  = mk("i_op0",    2'd1, 6'h00, 5'd1,  5'd2,  5'd0, 5'd0, 6'h00, 16'h1234, 26'h0,       1'b0, 32'h0);
        vecs[5]  = mk("i_op2",    2'd1, 6'h02, 5'd1,  5'd2,  5'd0, 5'd0, 6'h00, 16'h1234, 26'h0,       1'b0, 32'h0);
        vecs[6]  = mk("j_badop",  2'd2, 6'h08, 5'd0,  5'd0,  5'd0, 5'd0, 6'h00, 16'h0,    26'h0000123, 1'b0, 32'h0);
        vecs[7]  = mk("fmt3",     2'd3, 6'h00, 5'd1,  5'd2,  5'd3, 5'd0, 6'h21, 16'h0,    26'h0,       1'b0, 32'h0);
        vecs[8]  = mk("r_sll",    2'd0, 6'h00, 5'd0,  5'd9,  5'd8, 5'd4, 6'h00, 16'h0,    26'h0,       1'b1, 32'h00094100);
        vecs[9]  = mk("j_maxtgt", 2'd2, 6'h02, 5'd0,  5'd0,  5'd0, 5'd0, 6'h00, 16'h0,    26'h3FFFFFF, 1'b1, 32'h0BFFFFFF);
        vecs[10] = mk("i_lw",     2'd1, 6'h23, 5'd29, 5'd31, 5'd0, 5'd0, 6'h00, 16'h8000, 26'h0,       1'b1, 32'h8FBF8000);
        vecs[11] = mk("i_beq",    2'd1, 6'h04, 5'd0,  5'd0,  5'd0, 5'd0, 6'h00, 16'h0,    26'h0,       1'b1, 32'h10000000);

        // Reset state, checked while reset is still asserted.
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_count",     64'(count),     64'd0);
        check("rst_out_instr", 64'(out_instr), 64'd0);
        check("rst_out_addr",  64'(out_addr),  64'd0);
        check("rst_err",       64'(err),       64'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        step();
        check("rst_in_ready", 64'(in_ready), 64'd1);

        // Packing table: one bundle at a time, popped or error-cleared afterwards.
        exp_addr = 0;
        for (int i = 0; i < 12; i++) begin
            drive(vecs[i]);
            in_valid = 1'b1;
            step();
            in_valid = 1'b0;
            check({vecs[i].name, "_valid"}, 64'(out_valid), 64'(vecs[i].legal));
            check({vecs[i].name, "_err"},   64'(err),       64'(!vecs[i].legal));
            if (vecs[i].legal) begin
                check({vecs[i].name, "_instr"}, 64'(out_instr), 64'(vecs[i].instr));
                check({vecs[i].name, "_addr"},  64'(out_addr),  64'(exp_addr));
                check({vecs[i].name, "_count"}, 64'(count),     64'd1);
                out_ready = 1'b1;
                step();
                out_ready = 1'b0;
                check({vecs[i].name, "_drained"}, 64'(count), 64'd0);
                exp_addr++;
            end else begin
                check({vecs[i].name, "_count"}, 64'(count), 64'd0);
                err_clr = 1'b1;
                step();
                err_clr = 1'b0;
                check({vecs[i].name, "_errclr"}, 64'(err), 64'd0);
            end
        end

        // Full FIFO: fifth bundle is held until a pop frees a slot.
        reset = 1'b1;
        #1;
        reset = 1'b0;
        step();
        for (int k = 0; k < 4; k++) begin
            drive_addi(k);
            in_valid = 1'b1;
            step();
        end
        check("full_in_ready", 64'(in_ready), 64'd0);
        check("full_count",    64'(count),    64'd4);
        drive_addi(4);
        step();
        check("held_count", 64'(count), 64'd4);
        out_ready = 1'b1;
        #1;
        check("full_ready_indep", 64'(in_ready), 64'd0);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("drain%0d_valid", k), 64'(out_valid), 64'd1);
            check($sformatf("drain%0d_instr", k), 64'(out_instr), 64'(32'h20010000 + k));
            check($sformatf("drain%0d_addr", k),  64'(out_addr),  64'(k));
            if (k == 1) check("slot_freed_in_ready", 64'(in_ready), 64'd1);
            step();
            if (k == 1) in_valid = 1'b0;
        end
        out_ready = 1'b0;
        check("drain_count", 64'(count),     64'd0);
        check("drain_empty", 64'(out_valid), 64'd0);

        // Illegal bundle: error set, address counter holds at 5.
        fmt = 2'd2; op = 6'h08; target = 26'h1;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("ill_err",   64'(err),   64'd1);
        check("ill_count", 64'(count), 64'd0);
        drive(vecs[0]);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("after_ill_addr",  64'(out_addr),  64'd5);
        check("after_ill_instr", 64'(out_instr), 64'h00221821);
        check("err_sticky",      64'(err),       64'd1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("errclr_alone", 64'(err), 64'd0);
        fmt = 2'd3;
        in_valid = 1'b1;
        err_clr  = 1'b1;
        step();
        in_valid = 1'b0;
        err_clr  = 1'b0;
        check("err_set_wins", 64'(err),   64'd1);
        check("err_set_cnt",  64'(count), 64'd0);

        // Mid-stream reset discards queued words and restarts the address counter.
        for (int k = 0; k < 3; k++) begin
            drive_addi(k + 8);
            in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        check("pre_rst_count", 64'(count), 64'd3);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_valid", 64'(out_valid), 64'd0);
        check("async_rst_count", 64'(count),     64'd0);
        check("async_rst_err",   64'(err),       64'd0);
        #2;
        reset = 1'b0;
        step();
        drive(vecs[9]);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("post_rst_addr",  64'(out_addr),  64'd0);
        check("post_rst_instr", 64'(out_instr), 64'h0BFFFFFF);

        // Narrow address counter wraps under continuous push/pop.
        out_ready2 = 1'b1;
        in_valid2  = 1'b1;
        for (int k = 0; k < 6; k++) begin
            drive_addi(k + 16);
            step();
            check($sformatf("wrap%0d_addr", k),  64'(out_addr2),  64'(k % 4));
            check($sformatf("wrap%0d_instr", k), 64'(out_instr2), 64'(32'h20010000 + k + 16));
            check($sformatf("wrap%0d_count", k), 64'(count2),     64'd1);
        end
        in_valid2 = 1'b0;
        step();
        check("wrap_drained", 64'(count2), 64'd0);
        check("wrap_err",     64'(err2),   64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
